// File: rtl/userio_db15_scan.sv
// rtl/userio_db15_scan.sv - 74HC165 DB15 joystick chain scanner with two-scan debounce.
// Optional macro USERIO_DB15_PRESENT_EN adds the connected output and adapter-absent detection.
module userio_db15_scan #(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned NUM_BITS   = 24,
  parameter int unsigned IDLE_TICKS = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
`ifdef USERIO_DB15_PRESENT_EN
  output logic        connected,
`endif
  output logic        scan_done
);

  localparam int unsigned DIV_W  = $clog2(CLK_DIV);
  localparam int unsigned BIT_W  = $clog2(NUM_BITS);
  localparam int unsigned IDLE_W = $clog2(IDLE_TICKS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_HI,
    S_SHIFT_LO,
    S_DONE
  } state_t;

  state_t              state_q;
  logic [DIV_W-1:0]    div_q;
  logic [IDLE_W-1:0]   idle_q;
  logic [BIT_W-1:0]    bit_q;
  logic [NUM_BITS-1:0] raw_q;
  logic [NUM_BITS-1:0] prev_q;
  logic [11:0]         joy1_q;
  logic [11:0]         joy2_q;
  logic                joy_clk_q;
  logic                joy_load_q;
  logic                done_q;
  logic                tick;
`ifdef USERIO_DB15_PRESENT_EN
  logic                conn_q;
`endif

  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
    end else if (tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      idle_q     <= '0;
      bit_q      <= '0;
      raw_q      <= '0;
      prev_q     <= '0;
      joy1_q     <= '0;
      joy2_q     <= '0;
      joy_clk_q  <= 1'b0;
      joy_load_q <= 1'b1;
      done_q     <= 1'b0;
`ifdef USERIO_DB15_PRESENT_EN
      conn_q     <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (idle_q == IDLE_W'(IDLE_TICKS - 1)) begin
              idle_q     <= '0;
              joy_load_q <= 1'b0;
              state_q    <= S_LOAD;
            end else begin
              idle_q <= idle_q + 1'b1;
            end
          end
          S_LOAD: begin
            joy_load_q <= 1'b1;
            bit_q      <= '0;
            state_q    <= S_SHIFT_HI;
          end
          S_SHIFT_HI: begin
            // Sample before the rising joy_clk shifts the next bit out.
            raw_q[bit_q] <= ~joy_data;
            joy_clk_q    <= 1'b1;
            state_q      <= S_SHIFT_LO;
          end
          S_SHIFT_LO: begin
            joy_clk_q <= 1'b0;
            if (bit_q == BIT_W'(NUM_BITS - 1)) begin
              state_q <= S_DONE;
            end else begin
              bit_q   <= bit_q + 1'b1;
              state_q <= S_SHIFT_HI;
            end
          end
          S_DONE: begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
`ifdef USERIO_DB15_PRESENT_EN
            // An all-pressed scan means the data line is stuck low: no adapter.
            if (&raw_q) begin
              conn_q <= 1'b0;
              joy1_q <= '0;
              joy2_q <= '0;
              prev_q <= '0;
            end else begin
              conn_q <= 1'b1;
              if (raw_q == prev_q) begin
                joy1_q <= raw_q[11:0];
                joy2_q <= raw_q[23:12];
              end
              prev_q <= raw_q;
            end
`else
            if (raw_q == prev_q) begin
              joy1_q <= raw_q[11:0];
              joy2_q <= raw_q[23:12];
            end
            prev_q <= raw_q;
`endif
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign joy_clk   = joy_clk_q;
  assign joy_load  = joy_load_q;
  assign joystick1 = {4'b0000, joy1_q};
  assign joystick2 = {4'b0000, joy2_q};
  assign scan_done = done_q;
`ifdef USERIO_DB15_PRESENT_EN
  assign connected = conn_q;
`endif

endmodule

// File: tb/tb_userio_db15_scan.sv
// tb/tb_userio_db15_scan.sv - directed bench for userio_db15_scan with a 74HC165 chain model.
// Builds with or without USERIO_DB15_PRESENT_EN.
module tb_userio_db15_scan;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        scan_done;
`ifdef USERIO_DB15_PRESENT_EN
  logic        connected;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int jclk_edges = 0;
  int overlap = 0;
  logic [23:0] press = 24'h0;
  logic [23:0] sr = 24'hFFFFFF;

  userio_db15_scan #(.CLK_DIV(4), .NUM_BITS(24), .IDLE_TICKS(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .joy_data  (joy_data),
    .joy_clk   (joy_clk),
    .joy_load  (joy_load),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
`ifdef USERIO_DB15_PRESENT_EN
    .connected (connected),
`endif
    .scan_done (scan_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (joy_clk === 1'b1 && joy_load === 1'b0) overlap++;

  // Chain model: parallel load of active-low buttons, shift toward bit 0 on joy_clk rise.
  always @(negedge joy_load or posedge joy_clk) begin
    if (!joy_load) begin
      sr = ~press;
    end else begin
      sr = {1'b1, sr[23:1]};
      jclk_edges++;
    end
  end
  assign joy_data = sr[0];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  int last_cyc = 0;
  int last_edges = 0;

  task automatic wait_scan(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (scan_done !== 1'b1 && n < 1000);
    check({tag, "_timeout"}, 32'(n < 1000), 32'd1);
  endtask

  task automatic measure_load(input string tag);
    int n;
    int m;
    n = 0;
    while (joy_load === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_load_delay"}, 32'(n), 32'd12);
    m = 0;
    while (joy_load === 1'b0 && m < 100) begin
      @(negedge clk);
      m++;
    end
    check({tag, "_load_width"}, 32'(m), 32'd4);
  endtask

  initial begin
    press = 24'h400001;
    repeat (3) @(negedge clk);
    check("rst_joy_clk", 32'(joy_clk), 32'd0);
    check("rst_joy_load", 32'(joy_load), 32'd1);
    check("rst_j1", 32'(joystick1), 32'd0);
    check("rst_j2", 32'(joystick2), 32'd0);
    check("rst_done", 32'(scan_done), 32'd0);
    reset_n = 1'b1;
    measure_load("first");

    wait_scan("s1");
    last_cyc = cyc;
    check("s1_edges", 32'(jclk_edges), 32'd24);
    last_edges = jclk_edges;
    check("s1_j1", 32'(joystick1), 32'h0000);
    check("s1_j2", 32'(joystick2), 32'h0000);
`ifdef USERIO_DB15_PRESENT_EN
    check("s1_conn", 32'(connected), 32'd1);
`endif

    wait_scan("s2");
    check("s2_spacing", 32'(cyc - last_cyc), 32'd212);
    check("s2_edges", 32'(jclk_edges - last_edges), 32'd24);
    check("s2_j1", 32'(joystick1), 32'h0001);
    check("s2_j2", 32'(joystick2), 32'h0400);
    @(negedge clk);
    check("done_pulse_width", 32'(scan_done), 32'd0);

    press = 24'h0;
    wait_scan("s3");
    check("s3_j1_hold", 32'(joystick1), 32'h0001);
    wait_scan("s4");
    check("s4_j1", 32'(joystick1), 32'h0000);
    check("s4_j2", 32'(joystick2), 32'h0000);

    press = 24'h000008;
    wait_scan("s5");
    press = 24'h0;
    check("s5_glitch_j1", 32'(joystick1), 32'h0000);
    wait_scan("s6");
    check("s6_glitch_j1", 32'(joystick1), 32'h0000);

    press = 24'h000008;
    wait_scan("s7");
    check("s7_j1", 32'(joystick1), 32'h0000);
    wait_scan("s8");
    check("s8_j1", 32'(joystick1), 32'h0008);
    press = 24'h0;
    wait_scan("s9");
    check("s9_j1", 32'(joystick1), 32'h0008);
    wait_scan("s10");
    check("s10_j1", 32'(joystick1), 32'h0000);

    press = 24'hFFFFFF;
    wait_scan("s11");
    check("s11_j1", 32'(joystick1), 32'h0000);
    wait_scan("s12");
`ifdef USERIO_DB15_PRESENT_EN
    check("s12_j1", 32'(joystick1), 32'h0000);
    check("s12_j2", 32'(joystick2), 32'h0000);
    check("s12_conn", 32'(connected), 32'd0);
`else
    check("s12_j1", 32'(joystick1), 32'h0FFF);
    check("s12_j2", 32'(joystick2), 32'h0FFF);
`endif

    press = 24'h000001;
    wait_scan("s13");
`ifdef USERIO_DB15_PRESENT_EN
    check("s13_conn", 32'(connected), 32'd1);
    check("s13_j1", 32'(joystick1), 32'h0000);
`else
    check("s13_j1", 32'(joystick1), 32'h0FFF);
`endif
    wait_scan("s14");
    check("s14_j1", 32'(joystick1), 32'h0001);
    check("s14_j2", 32'(joystick2), 32'h0000);

    begin
      int n;
      n = 0;
      while (joy_clk !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("mid_shift_reached", 32'(n < 1000), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_joy_clk", 32'(joy_clk), 32'd0);
    check("mid_rst_joy_load", 32'(joy_load), 32'd1);
    check("mid_rst_j1", 32'(joystick1), 32'h0000);
    check("mid_rst_j2", 32'(joystick2), 32'h0000);
    check("mid_rst_done", 32'(scan_done), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    measure_load("after_rst");
    wait_scan("r1");
    check("r1_j1", 32'(joystick1), 32'h0000);
    wait_scan("r2");
    check("r2_j1", 32'(joystick1), 32'h0001);

    check("never_overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/userio_db15_scan.md
Name: userio_db15_scan

Overview:
- Upstream stage of the top-level joystick mux; produces the two DB15 joystick words that the mux selects when UserIO DB15 mode is enabled.
- Drives the external 74HC165 shift-register chain on the User port (JOY_LOAD, JOY_CLK) and serially samples JOY_DATA.
- Delivers debounced, active-high 12-button words in the codebase layout: bit0 R, 1 L, 2 D, 3 U, 4 A, 5 B, 6 C, 7 X, 8 Y, 9 Z, 10 Start, 11 Mode/Select.

Parameters:
- CLK_DIV, 16: clk cycles per tick; tick is the shift-timing enable; must be ≥2.
- NUM_BITS, 24: shift-chain length; bits 0..11 joystick 1, bits 12..23 joystick 2.
- IDLE_TICKS, 1000: ticks spent in IDLE between scans; must be ≥1.

Ports:
- clk  in  1  system clock, 40-50 MHz
- reset_n  in  1  asynchronous active-low reset
- joy_data  in  1  serial data from the chain; 0 = pressed
- joy_clk  out  1  shift clock to the chain
- joy_load  out  1  parallel load to the chain, active low
- joystick1  out  16  {4'b0, buttons[11:0]} for player 1, 1 = pressed
- joystick2  out  16  {4'b0, buttons[11:0]} for player 2
- scan_done  out  1  one-clk pulse at the end of each scan

Behaviour:
- Reset is asynchronous, active-low; clk is the single clock.
- Reset values: joy_clk=0, joy_load=1, joystick1=joystick2=0, scan_done=0, state IDLE, all counters 0, raw and prev registers 0.
- Tick generation:
  - Divider counts 0..CLK_DIV-1 and asserts tick for one clk when it wraps.
  - The divider free-runs after reset.
  - All state-machine actions below occur only on tick cycles; scan_done is the only exception.
- IDLE:
  - Counts IDLE_TICKS ticks with joy_load=1 and joy_clk=0, then goes to LOAD.
- LOAD:
  - joy_load=0 for exactly one tick, then joy_load=1.
  - Bit counter clears to 0; next state SHIFT_HI.
- SHIFT_HI:
  - raw[bit] <= ~joy_data, sampled on this tick; then joy_clk <= 1.
  - Next state SHIFT_LO.
- SHIFT_LO:
  - joy_clk <= 0.
  - If bit == NUM_BITS-1, go to DONE; otherwise bit++ and go to SHIFT_HI.
- DONE (one tick):
  - If raw == prev: joystick1 <= {4'b0, raw[11:0]} and joystick2 <= {4'b0, raw[23:12]}. This is the two-scan debounce.
  - prev <= raw in every case.
  - scan_done=1 for exactly one clk; state returns to IDLE.
- Scan length is IDLE_TICKS + 1 + 2*NUM_BITS + 1 ticks.
- Output latency: a stable input change appears on the outputs at the end of the second full scan after it. An input that changes between two scans is never presented until it holds for two scans.
- No partial update: the outputs change only in DONE, and both words change in the same clk.
- Reset mid-scan: all state is dropped and outputs are zeroed immediately. After reset is released, the first DONE cannot update the outputs unless raw equals the zero prev, so a real change needs two scans.
- joy_clk and joy_load are registered and glitch-free; they are never active together.
- Bits of raw at index NUM_BITS or above do not exist. Upper output bits 15:12 are always 0.

Optional Feature:
- Macro: USERIO_DB15_PRESENT_EN.
- When defined:
  - Adds output port connected (1 bit, reset 0).
  - At DONE, a scan in which every raw bit is 1 (data line stuck low, i.e. no adapter) is treated as absent.
  - On an absent scan: connected <= 0, joystick1 and joystick2 are forced to 0, and prev is cleared to 0.
  - On any other scan: connected <= 1 and the normal debounce applies.
- When undefined:
  - No connected port.
  - An all-ones raw scan is passed through the debounce like any other value.

Test Plan:
- Reset check: assert reset_n=0 mid-SHIFT -> joy_clk=0, joy_load=1, joystick1=joystick2=0, scan_done=0 in the same cycle; after release, joy_load first goes low after exactly IDLE_TICKS*CLK_DIV clk.
- Framing, with CLK_DIV=4, IDLE_TICKS=3: count per scan -> exactly 24 joy_clk rising edges, one joy_load low pulse of 4 clk, scan_done spaced (3+1+48+1)*4=212 clk apart.
- Data mapping: the chain model presents player 1 R (bit0) and player 2 Start (bit22) pressed, constant -> joystick1=16'h0001 and joystick2=16'h0400 after the second scan_done; both still 0 after the first.
- Debounce: press bit3 (U, player 1) for one scan only -> joystick1 stays 16'h0000; hold for two scans -> 16'h0008; release -> returns to 0 after two scans.
- All buttons: all 24 pressed for two scans -> joystick1=joystick2=16'h0FFF (macro undefined); with USERIO_DB15_PRESENT_EN -> outputs 0 and connected=0, then a single press of bit0 -> connected=1 after one scan and joystick1=16'h0001 after two.
